// File: rtl/calc_combinatorics_sequencer.sv
// rtl/calc_combinatorics_sequencer.sv - multi-cycle factorial / nPr / nCr sequencer
// One multiply (plus one exact divide for nCr) per cycle on a shared 64-bit datapath.
module calc_combinatorics_sequencer #(
   parameter int OPW  = 16,
   parameter int RESW = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            abort,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [OPW-1:0]  req_a,
   input  logic [OPW-1:0]  req_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [RESW-1:0] rsp_result,
   output logic            rsp_ovf,
   output logic            rsp_err,
   output logic            busy
);
   localparam logic [2:0]      OP_FACT = 3'd0;
   localparam logic [2:0]      OP_PERM = 3'd1;
   localparam logic [2:0]      OP_COMB = 3'd2;
   localparam logic [63:0]     MAX_W   = (64'd1 << (RESW-1)) - 64'd1;
   localparam logic [RESW-1:0] MAX_R   = MAX_W[RESW-1:0];

   typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_t;

   state_t          state_q;
   logic [2:0]      op_q;
   logic [OPW-1:0]  a_q, b_q, i_q, n_q;
   logic [RESW-1:0] acc_q, rsp_result_q;
   logic            req_ready_q, rsp_valid_q, rsp_ovf_q, rsp_err_q, busy_q;

   logic            bad_d, last_d;
   logic [OPW-1:0]  amb_d, n_d;
   logic [63:0]     a_w, i_w, n_w, inc_w, factor_d, prod_d, p_d;

   always_comb begin
      amb_d = a_q - b_q;
      // Negative operands make the unsigned b>a compare meaningless, but they already flag bad.
      bad_d = a_q[OPW-1] || (op_q > OP_COMB) ||
              ((op_q != OP_FACT) && (b_q[OPW-1] || (b_q > a_q)));
      case (op_q)
         OP_FACT: n_d = a_q;
         OP_PERM: n_d = b_q;
         default: n_d = (b_q < amb_d) ? b_q : amb_d;
      endcase
      a_w   = 64'(a_q);
      i_w   = 64'(i_q);
      n_w   = 64'(n_q);
      inc_w = i_w + 64'd1;
      case (op_q)
         OP_FACT: factor_d = inc_w;
         OP_PERM: factor_d = a_w - i_w;
         default: factor_d = a_w - n_w + inc_w;
      endcase
      prod_d = 64'(acc_q) * factor_d;
      p_d    = (op_q == OP_COMB) ? prod_d / inc_w : prod_d;
      last_d = (inc_w == n_w);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         i_q          <= '0;
         n_q          <= '0;
         acc_q        <= RESW'(1);
         rsp_result_q <= '0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_ovf_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
               op_q        <= req_op;
               a_q         <= req_a;
               b_q         <= req_b;
               state_q     <= INIT;
               req_ready_q <= 1'b0;
               busy_q      <= 1'b1;
            end
            INIT: if (abort) begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end else begin
               acc_q <= RESW'(1);
               i_q   <= '0;
               n_q   <= bad_d ? '0 : n_d;
               if (bad_d || n_d == '0) begin
                  state_q      <= DONE;
                  rsp_valid_q  <= 1'b1;
                  rsp_err_q    <= bad_d;
                  rsp_result_q <= bad_d ? '0 : RESW'(1);
               end else begin
                  state_q <= ITER;
               end
            end
            ITER: if (abort) begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end else if (p_d > MAX_W) begin
               acc_q        <= MAX_R;
               rsp_result_q <= MAX_R;
               rsp_ovf_q    <= 1'b1;
               rsp_valid_q  <= 1'b1;
               state_q      <= DONE;
            end else begin
               acc_q <= p_d[RESW-1:0];
               i_q   <= i_q + 1'b1;
               if (last_d) begin
                  rsp_result_q <= p_d[RESW-1:0];
                  rsp_valid_q  <= 1'b1;
                  state_q      <= DONE;
               end
            end
            DONE: if (rsp_ready) begin
               state_q      <= IDLE;
               rsp_valid_q  <= 1'b0;
               rsp_ovf_q    <= 1'b0;
               rsp_err_q    <= 1'b0;
               rsp_result_q <= '0;
               req_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_ovf    = rsp_ovf_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = busy_q;
endmodule
